// File: rtl/rca_accumulator.sv
// Frame accumulator wrapped around an external N-bit ripple-carry adder.
// Counts adder carries per frame and presents {carry_cnt, acc} once the frame ends.
module rca_accumulator #(
    parameter int N     = 3,
    parameter int BEATS = 4,
    parameter int CW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    input  logic            in_last,
    output logic [N-1:0]    add_a,
    output logic [N-1:0]    add_b,
    output logic            add_cin,
    input  logic [N-1:0]    add_sum,
    input  logic            add_cout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N+CW-1:0] out_sum,
    output logic            out_ovf
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic {ACC, HOLD} state_t;

    state_t          state;
    logic [N-1:0]    acc;
    logic [CW-1:0]   carry_cnt;
    logic [BW-1:0]   beat;
    logic            ovf;
    logic            accept;
    logic            frame_end;

    // Saturating carry counter: sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic inc);
        if (inc && cnt != CNT_MAX)
            return cnt + CW'(1);
        return cnt;
    endfunction

    assign add_a     = acc;
    assign add_b     = in_data;
    assign add_cin   = 1'b0;

    // Handshake outputs depend only on the state register, so out_ready never reaches in_ready.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign out_sum   = {carry_cnt, acc};
    assign out_ovf   = ovf;

    assign accept    = in_valid && in_ready;
    assign frame_end = (beat == LAST_BEAT) || in_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            carry_cnt <= '0;
            beat      <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc       <= add_sum;
                        carry_cnt <= sat_inc(carry_cnt, add_cout);
                        ovf       <= ovf | (add_cout & (carry_cnt == CNT_MAX));
                        if (frame_end) begin
                            beat  <= '0;
                            state <= HOLD;
                        end else begin
                            beat  <= beat + BW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc       <= '0;
                        carry_cnt <= '0;
                        ovf       <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed bench for rca_accumulator with ideal adders; a CW=1 copy exercises carry saturation.
module tb_rca_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_ovf, add_cin, add_cout;
    logic [2:0] add_a, add_b, add_sum;
    logic [5:0] out_sum;

    logic       in_ready1, out_valid1, out_ovf1, add_cin1, add_cout1;
    logic [2:0] add_a1, add_b1, add_sum1;
    logic [3:0] out_sum1;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum}   = 4'(add_a) + 4'(add_b) + 4'(add_cin);
    assign {add_cout1, add_sum1} = 4'(add_a1) + 4'(add_b1) + 4'(add_cin1);

    rca_accumulator #(.N(3), .BEATS(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    rca_accumulator #(.N(3), .BEATS(4), .CW(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .add_a(add_a1), .add_b(add_b1),
        .add_cin(add_cin1), .add_sum(add_sum1), .add_cout(add_cout1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1), .out_ovf(out_ovf1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [2:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_out_sum", 8'(out_sum), 8'd0);
        chk("rst_out_ovf", 8'(out_ovf), 8'd0);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        // Async reset asserted between edges must take effect immediately.
        #3 rst = 1'b1;
        #1;
        chk("rst0_in_ready", 8'(in_ready), 8'd1);
        chk("rst0_out_valid", 8'(out_valid), 8'd0);
        chk("rst0_out_sum", 8'(out_sum), 8'd0);
        chk("rst0_out_ovf", 8'(out_ovf), 8'd0);
        chk("rst0_cw1_in_ready", 8'(in_ready1), 8'd1);
        @(negedge clk) rst = 1'b0;

        // 1+2+3+1 = 7, no carries
        send(3'd1, 1'b0); send(3'd2, 1'b0); send(3'd3, 1'b0);
        chk("f1_valid_before_end", 8'(out_valid), 8'd0);
        send(3'd1, 1'b0);
        chk("f1_out_valid", 8'(out_valid), 8'd1);
        chk("f1_in_ready", 8'(in_ready), 8'd0);
        chk("f1_out_sum", 8'(out_sum), 8'h07);
        chk("f1_out_ovf", 8'(out_ovf), 8'd0);
        ack();
        chk("f1_ack_valid", 8'(out_valid), 8'd0);
        chk("f1_ack_in_ready", 8'(in_ready), 8'd1);
        chk("f1_ack_cleared", 8'(out_sum), 8'd0);

        // 7*4 = 28 = 3*8 + 4; CW=1 copy saturates its count at 1 and flags overflow
        repeat (4) send(3'd7, 1'b0);
        chk("f2_out_valid", 8'(out_valid), 8'd1);
        chk("f2_out_sum", 8'(out_sum), 8'h1C);
        chk("f2_out_ovf", 8'(out_ovf), 8'd0);
        chk("f2_cw1_out_sum", 8'(out_sum1), 8'h0C);
        chk("f2_cw1_out_ovf", 8'(out_ovf1), 8'd1);
        ack();
        chk("f2_cw1_ovf_clear", 8'(out_ovf1), 8'd0);

        // Early end: 5 + 6 = 11 = 1*8 + 3
        send(3'd5, 1'b0);
        chk("f3_valid_mid", 8'(out_valid), 8'd0);
        send(3'd6, 1'b1);
        chk("f3_out_valid", 8'(out_valid), 8'd1);
        chk("f3_out_sum", 8'(out_sum), 8'h0B);

        // Backpressure: held result ignores incoming operands
        in_valid = 1'b1;
        in_data  = 3'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 8'(in_ready), 8'd0);
            chk("bp_out_sum", 8'(out_sum), 8'h0B);
        end
        ack();
        chk("bp_rel_in_ready", 8'(in_ready), 8'd1);
        chk("bp_rel_valid", 8'(out_valid), 8'd0);
        chk("bp_rel_sum", 8'(out_sum), 8'd0);
        send(3'd2, 1'b0);
        chk("bp_next_acc", 8'(out_sum), 8'h02);

        // Reset mid-frame discards the partial result
        reset_pulse();
        send(3'd3, 1'b0); send(3'd4, 1'b0);
        chk("f6_partial", 8'(out_sum), 8'h07);
        reset_pulse();
        repeat (3) send(3'd1, 1'b0);
        chk("f6_valid_before_end", 8'(out_valid), 8'd0);
        send(3'd1, 1'b0);
        chk("f6_out_valid", 8'(out_valid), 8'd1);
        chk("f6_out_sum", 8'(out_sum), 8'h04);
        ack();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
